// File: rtl/ets_pkg.sv
// rtl/ets_pkg.sv - shared ETS constants: state encoding, phase modulus default, vernier width
// Contents:
//   ets_state_t            4-bit state code shared with the other ETS controllers
//   ST_IDLE..ST_DONE       state codes
//   ETS_PHASE_MAX_DEFAULT  default phase index modulus
//   VERNIER_W              width of the exported phase index
package ets_pkg;

  localparam int ETS_STATE_W = 4;
  typedef logic [ETS_STATE_W-1:0] ets_state_t;

  localparam ets_state_t ST_IDLE  = 4'h0;
  localparam ets_state_t ST_ISSUE = 4'h1;
  localparam ets_state_t ST_WAIT  = 4'h2;
  localparam ets_state_t ST_NEXT  = 4'h3;
  localparam ets_state_t ST_DONE  = 4'h4;

  localparam int ETS_PHASE_MAX_DEFAULT = 5600;
  localparam int VERNIER_W             = 32;

  // Index width for a modulus, never below one bit.
  function automatic int idx_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/phase_wrap_counter.sv
// rtl/phase_wrap_counter.sv - modulo up/down counter holding the Vernier phase index
// Ports:
//   sample_clk  in   clock, rising edge
//   rst_n       in   asynchronous active-low reset, clears the index
//   clr         in   synchronous clear to 0 (has priority over en)
//   en          in   advance the index by one this cycle
//   up          in   1 = increment, 0 = decrement
//   count       out  current index, zero-extended to OUT_W
module phase_wrap_counter
  import ets_pkg::*;
#(
  parameter int MODULUS = ETS_PHASE_MAX_DEFAULT,
  parameter int OUT_W   = VERNIER_W
) (
  input  logic             sample_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  output logic [OUT_W-1:0] count
);

  localparam int IDX_W = idx_width(MODULUS);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MODULUS - 1);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (en) begin
      if (up) begin
        idx_q <= (idx_q == IDX_TOP) ? '0 : idx_q + IDX_W'(1);
      end else begin
        idx_q <= (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
      end
    end
  end

  assign count = OUT_W'(idx_q);

endmodule

// File: rtl/ets_phase_stepper.sv
// rtl/ets_phase_stepper.sv - sequences MMCM dynamic phase steps for the ETS sampling sweep
// Optional feature macro: ETS_PS_TIMEOUT_EN (per-step psdone watchdog).
// Ports:
//   sample_clk   in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   shift        in   step request pulse, accepted only in IDLE
//   dir          in   1 = increment phase, 0 = decrement; sampled with shift
//   clear        in   zero vernier_q and timeout_err, honoured only in IDLE
//   shift_done   out  one-cycle pulse ending each accepted request
//   psen         out  MMCM phase-shift enable, one pulse per step
//   psincdec     out  MMCM direction, latched dir
//   psdone       in   MMCM step acknowledge
//   vernier_q    out  phase index 0..PHASE_MAX-1, zero-extended
//   busy         out  high outside IDLE
//   timeout_err  out  sticky step-timeout flag (0 without the watchdog)
module ets_phase_stepper
  import ets_pkg::*;
#(
  parameter int STEPS_PER_SHIFT = 1,
  parameter int PHASE_MAX       = ETS_PHASE_MAX_DEFAULT,
  parameter int PS_TIMEOUT      = 1023
) (
  input  logic                 sample_clk,
  input  logic                 rst_n,
  input  logic                 shift,
  input  logic                 dir,
  input  logic                 clear,
  output logic                 shift_done,
  output logic                 psen,
  output logic                 psincdec,
  input  logic                 psdone,
  output logic [VERNIER_W-1:0] vernier_q,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int STEP_W = $clog2(STEPS_PER_SHIFT + 1);

  ets_state_t        state_q;
  ets_state_t        state_d;
  logic [STEP_W-1:0] step_cnt_q;
  logic              dir_q;
  logic              accept;
  logic              do_clear;
  logic              step_ack;
  logic              timeout_hit;

  // clear wins over a same-cycle shift, and both only count in IDLE.
  assign do_clear = (state_q == ST_IDLE) && clear;
  assign accept   = (state_q == ST_IDLE) && !clear && shift;
  // psdone is only meaningful while a step is outstanding; strays elsewhere drop.
  assign step_ack = (state_q == ST_WAIT) && psdone;

`ifdef ETS_PS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(PS_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_err_q;

  // Counts cycles spent in WAIT; a step that is acknowledged on the very last
  // allowed cycle still counts as acknowledged.
  assign timeout_hit = (state_q == ST_WAIT) && !psdone &&
                       (wait_cnt_q == WAIT_W'(PS_TIMEOUT - 1));

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end else begin
        wait_cnt_q <= '0;
      end
      if (do_clear) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_ps_timeout;
  assign unused_ps_timeout = |PS_TIMEOUT;
  assign timeout_hit       = 1'b0;
  assign timeout_err       = 1'b0;
`endif

  // State register
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (psdone) begin
          state_d = ST_NEXT;
        end else if (timeout_hit) begin
          // Remaining steps are abandoned, but the requester still gets its done.
          state_d = ST_DONE;
        end
      end
      ST_NEXT: begin
        state_d = (step_cnt_q < STEP_W'(STEPS_PER_SHIFT)) ? ST_ISSUE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    psen       = 1'b0;
    shift_done = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE:  busy       = 1'b0;
      ST_ISSUE: psen       = 1'b1;
      ST_DONE:  shift_done = 1'b1;
      default:  ;
    endcase
  end

  // Request bookkeeping: direction latch and completed-step count.
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      if (accept) begin
        dir_q      <= dir;
        step_cnt_q <= '0;
      end else if (step_ack) begin
        step_cnt_q <= step_cnt_q + STEP_W'(1);
      end
    end
  end

  assign psincdec = dir_q;

  phase_wrap_counter #(
    .MODULUS (PHASE_MAX),
    .OUT_W   (VERNIER_W)
  ) u_vernier (
    .sample_clk (sample_clk),
    .rst_n      (rst_n),
    .clr        (do_clear),
    .en         (step_ack),
    .up         (dir_q),
    .count      (vernier_q)
  );

endmodule

// File: tb/tb_ets_phase_stepper.sv
// tb/tb_ets_phase_stepper.sv - directed, table-driven bench for ets_phase_stepper
module tb_ets_phase_stepper;

  localparam int PS_TIMEOUT = 1023;

  logic        sample_clk = 1'b0;
  logic        rst_n;

  logic        shift_a, dir_a, clear_a, psdone_a;
  logic        shift_done_a, psen_a, psincdec_a, busy_a, timeout_err_a;
  logic [31:0] vernier_a;

  logic        shift_b, dir_b, clear_b, psdone_b;
  logic        shift_done_b, psen_b, psincdec_b, busy_b, timeout_err_b;
  logic [31:0] vernier_b;

  int checks = 0;
  int passes = 0;

  always #5 sample_clk = ~sample_clk;

  ets_phase_stepper #(.STEPS_PER_SHIFT(1), .PHASE_MAX(5600), .PS_TIMEOUT(PS_TIMEOUT)) u_dut_a (
    .sample_clk (sample_clk), .rst_n (rst_n),
    .shift (shift_a), .dir (dir_a), .clear (clear_a),
    .shift_done (shift_done_a), .psen (psen_a), .psincdec (psincdec_a),
    .psdone (psdone_a), .vernier_q (vernier_a), .busy (busy_a),
    .timeout_err (timeout_err_a)
  );

  ets_phase_stepper #(.STEPS_PER_SHIFT(4), .PHASE_MAX(5600), .PS_TIMEOUT(PS_TIMEOUT)) u_dut_b (
    .sample_clk (sample_clk), .rst_n (rst_n),
    .shift (shift_b), .dir (dir_b), .clear (clear_b),
    .shift_done (shift_done_b), .psen (psen_b), .psincdec (psincdec_b),
    .psdone (psdone_b), .vernier_q (vernier_b), .busy (busy_b),
    .timeout_err (timeout_err_b)
  );

  typedef struct {
    bit clr;
    bit dir;
    int delay;   // cycles from psen to psdone (>=1)
    int exp_v;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic do_clear_a();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clear_vernier", int'(vernier_a), 0);
    check("clear_busy", int'(busy_a), 0);
  endtask

  // One request on DUT A; shift is re-pulsed (with the opposite dir) while busy.
  task automatic txn_a(input bit d, input int delay, input int exp_v, input int idx);
    int psens;
    int dones;
    int done_at;
    psens   = 0;
    dones   = 0;
    done_at = -1;
    shift_a = 1'b1;
    dir_a   = d;
    tick();
    shift_a = 1'b0;
    check($sformatf("v%0d_psen_cycle1", idx), int'(psen_a), 1);
    check($sformatf("v%0d_psincdec", idx), int'(psincdec_a), int'(d));
    psens = 1;
    for (int i = 0; i < delay; i++) begin
      shift_a = (i % 2 == 0);
      dir_a   = ~d;
      tick();
      shift_a = 1'b0;
      if (psen_a) psens++;
    end
    dir_a    = d;
    psdone_a = 1'b1;
    tick();
    psdone_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (psen_a) psens++;
      if (shift_done_a) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
      tick();
    end
    check($sformatf("v%0d_psen_count", idx), psens, 1);
    check($sformatf("v%0d_done_count", idx), dones, 1);
    check($sformatf("v%0d_done_after_psdone", idx), done_at, 2);
    check($sformatf("v%0d_vernier", idx), int'(vernier_a), exp_v);
    check($sformatf("v%0d_idle", idx), int'(busy_a), 0);
  endtask

  initial begin
    int psens;
    int dones;
    int done_at;
    int due;

    vecs[0]  = '{clr: 0, dir: 1, delay: 12, exp_v: 1};
    vecs[1]  = '{clr: 1, dir: 0, delay: 1,  exp_v: 5599};
    vecs[2]  = '{clr: 0, dir: 1, delay: 3,  exp_v: 0};
    vecs[3]  = '{clr: 0, dir: 1, delay: 1,  exp_v: 1};
    vecs[4]  = '{clr: 0, dir: 1, delay: 2,  exp_v: 2};
    vecs[5]  = '{clr: 0, dir: 0, delay: 4,  exp_v: 1};
    vecs[6]  = '{clr: 0, dir: 0, delay: 1,  exp_v: 0};
    vecs[7]  = '{clr: 0, dir: 0, delay: 5,  exp_v: 5599};
    vecs[8]  = '{clr: 0, dir: 0, delay: 1,  exp_v: 5598};
    vecs[9]  = '{clr: 0, dir: 1, delay: 1,  exp_v: 5599};
    vecs[10] = '{clr: 0, dir: 1, delay: 2,  exp_v: 0};
    vecs[11] = '{clr: 0, dir: 1, delay: 6,  exp_v: 1};

    rst_n = 1'b0;
    {shift_a, dir_a, clear_a, psdone_a} = '0;
    {shift_b, dir_b, clear_b, psdone_b} = '0;
    repeat (3) tick();
    check("rst_a_psen", int'(psen_a), 0);
    check("rst_a_done", int'(shift_done_a), 0);
    check("rst_a_busy", int'(busy_a), 0);
    check("rst_a_psincdec", int'(psincdec_a), 0);
    check("rst_a_vernier", int'(vernier_a), 0);
    check("rst_a_timeout", int'(timeout_err_a), 0);
    check("rst_b_vernier", int'(vernier_b), 0);
    check("rst_b_busy", int'(busy_b), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven single-step requests including both wrap directions.
    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear_a();
      txn_a(vecs[i].dir, vecs[i].delay, vecs[i].exp_v, i);
    end

    // Stray psdone while idle is ignored.
    psens = 0;
    psdone_a = 1'b1;
    tick();
    psdone_a = 1'b0;
    if (psen_a) psens++;
    tick();
    if (psen_a) psens++;
    check("stray_psdone_vernier", int'(vernier_a), 1);
    check("stray_psdone_busy", int'(busy_a), 0);
    check("stray_psdone_psen", psens, 0);

    // clear and shift together: clear wins, shift dropped.
    clear_a = 1'b1;
    shift_a = 1'b1;
    dir_a   = 1'b1;
    tick();
    clear_a = 1'b0;
    shift_a = 1'b0;
    check("clr_shift_busy", int'(busy_a), 0);
    check("clr_shift_psen", int'(psen_a), 0);
    check("clr_shift_vernier", int'(vernier_a), 0);
    tick();
    check("clr_shift_psen_late", int'(psen_a), 0);

    // Withheld psdone.
    shift_a = 1'b1;
    dir_a   = 1'b1;
    tick();
    shift_a = 1'b0;
`ifdef ETS_PS_TIMEOUT_EN
    done_at = -1;
    for (int c = 2; c <= 1200; c++) begin
      tick();
      if (shift_done_a) begin
        done_at = c;
        break;
      end
    end
    check("timeout_done_cycle", done_at, PS_TIMEOUT + 2);
    check("timeout_err_set", int'(timeout_err_a), 1);
    check("timeout_vernier", int'(vernier_a), 0);
    tick();
    check("timeout_idle", int'(busy_a), 0);
    check("timeout_err_sticky", int'(timeout_err_a), 1);
    do_clear_a();
    check("timeout_err_cleared", int'(timeout_err_a), 0);
`else
    dones = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (shift_done_a) dones++;
    end
    check("nowd_no_done", dones, 0);
    check("nowd_still_busy", int'(busy_a), 1);
    check("nowd_timeout_err", int'(timeout_err_a), 0);
    psdone_a = 1'b1;
    tick();
    psdone_a = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 8; k++) begin
      if (shift_done_a && done_at < 0) done_at = k;
      tick();
    end
    check("nowd_done_after_psdone", done_at, 2);
    check("nowd_vernier", int'(vernier_a), 1);
    do_clear_a();
`endif

    // Four steps per request, psdone 5 cycles after each psen.
    psens   = 0;
    dones   = 0;
    done_at = -1;
    due     = -1;
    shift_b = 1'b1;
    dir_b   = 1'b1;
    tick();
    shift_b = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (psen_b) begin
        psens++;
        due = cyc + 5;
      end
      psdone_b = (cyc == due);
      if (shift_done_b) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      tick();
    end
    psdone_b = 1'b0;
    check("b_psen_count", psens, 4);
    check("b_done_count", dones, 1);
    check("b_done_cycle", done_at, 29);
    check("b_vernier", int'(vernier_b), 4);
    check("b_psincdec", int'(psincdec_b), 1);
    check("b_idle", int'(busy_b), 0);

    // Asynchronous reset mid-WAIT; the late psdone must be ignored.
    txn_a(1'b1, 2, 1, 100);
    shift_a = 1'b1;
    dir_a   = 1'b1;
    tick();
    shift_a = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check("arst_psen", int'(psen_a), 0);
    check("arst_done", int'(shift_done_a), 0);
    check("arst_busy", int'(busy_a), 0);
    check("arst_psincdec", int'(psincdec_a), 0);
    check("arst_vernier", int'(vernier_a), 0);
    check("arst_timeout", int'(timeout_err_a), 0);
    tick();
    rst_n = 1'b1;
    psdone_a = 1'b1;
    tick();
    psdone_a = 1'b0;
    tick();
    check("late_psdone_vernier", int'(vernier_a), 0);
    check("late_psdone_busy", int'(busy_a), 0);
    check("late_psdone_psen", int'(psen_a), 0);
    txn_a(1'b0, 1, 5599, 101);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
